// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
// slave = arbiter side, master = requesters plus memory environment.
interface mem_arbiter_if;
   logic        i_req_i;
   logic        i_we_i;
   logic [3:0]  i_be_i;
   logic [31:0] i_addr_i;
   logic [31:0] i_wdata_i;
   logic [31:0] i_rdata_o;
   logic        i_ready_o;

   logic        d_req_i;
   logic        d_we_i;
   logic [3:0]  d_be_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_ready_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ready_i;

   logic        busy_o;

   modport slave (
      input  i_req_i, i_we_i, i_be_i, i_addr_i, i_wdata_i,
      output i_rdata_o, i_ready_o,
      input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      output d_rdata_o, d_ready_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ready_i,
      output busy_o
   );

   modport master (
      output i_req_i, i_we_i, i_be_i, i_addr_i, i_wdata_i,
      input  i_rdata_o, i_ready_o,
      output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
      input  d_rdata_o, d_ready_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ready_i,
      input  busy_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter onto one memory port, IDLE/ISSUE/RESP
// Optional ARB_ROUND_ROBIN_EN: alternate ties; otherwise the data port wins ties.
module mem_arbiter (
   input logic          clk_i,
   input logic          rst_ni,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t      state;
   logic        gnt_d;
   logic        busy_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        i_ready_q;
   logic        d_ready_q;
   logic        i_rd_q;
   logic        d_rd_q;
   logic        win_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic prio_d;
   assign win_d = bus.d_req_i & (~bus.i_req_i | prio_d);
`else
   assign win_d = bus.d_req_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= IDLE;
         gnt_d       <= 1'b0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'b0;
         mem_addr_q  <= 32'b0;
         mem_wdata_q <= 32'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rd_q      <= 1'b0;
         d_rd_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         prio_d      <= 1'b1;
`endif
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         i_rd_q    <= 1'b0;
         d_rd_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req_i || bus.d_req_i) begin
                  state       <= ISSUE;
                  busy_q      <= 1'b1;
                  mem_req_q   <= 1'b1;
                  gnt_d       <= win_d;
                  mem_we_q    <= win_d ? bus.d_we_i    : bus.i_we_i;
                  mem_be_q    <= win_d ? bus.d_be_i    : bus.i_be_i;
                  mem_addr_q  <= win_d ? bus.d_addr_i  : bus.i_addr_i;
                  mem_wdata_q <= win_d ? bus.d_wdata_i : bus.i_wdata_i;
               end
            end
            ISSUE: begin
               if (bus.mem_ready_i) begin
                  state     <= RESP;
                  mem_req_q <= 1'b0;
                  d_ready_q <= gnt_d;
                  i_ready_q <= ~gnt_d;
                  // read-data steering flags line up with the memory's one-cycle read latency
                  d_rd_q    <= gnt_d & ~mem_we_q;
                  i_rd_q    <= ~gnt_d & ~mem_we_q;
`ifdef ARB_ROUND_ROBIN_EN
                  prio_d    <= ~gnt_d;
`endif
               end
            end
            RESP: begin
               state       <= IDLE;
               busy_q      <= 1'b0;
               gnt_d       <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_be_q    <= 4'b0;
               mem_addr_q  <= 32'b0;
               mem_wdata_q <= 32'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_be_o    = mem_be_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.i_ready_o   = i_ready_q;
   assign bus.d_ready_o   = d_ready_q;
   assign bus.i_rdata_o   = i_rd_q ? bus.mem_rdata_i : 32'b0;
   assign bus.d_rdata_o   = d_rd_q ? bus.mem_rdata_i : 32'b0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Includes a small byte-enabled memory with one-cycle read latency.
module tb_mem_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [31:0] mem [0:63];
   logic [7:0]  rbyte;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
         mem[4] <= 32'hDEADBEEF;
         mem[2] <= 32'h12345678;
         bus.mem_rdata_i <= 32'h0;
      end else if (bus.mem_req_o && bus.mem_ready_i) begin
         if (bus.mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_be_o[b])
                  mem[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
         end else begin
            bus.mem_rdata_i <= mem[bus.mem_addr_o[7:2]];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      logic exp_d;
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.i_req_i = 0; bus.i_we_i = 0; bus.i_be_i = 4'hF; bus.i_addr_i = 0; bus.i_wdata_i = 0;
      bus.d_req_i = 0; bus.d_we_i = 0; bus.d_be_i = 4'hF; bus.d_addr_i = 0; bus.d_wdata_i = 0;
      bus.mem_ready_i = 1'b1;
      repeat (3) tick();
      check("rst_busy", {31'b0, bus.busy_o}, 0);
      check("rst_mem_req", {31'b0, bus.mem_req_o}, 0);
      check("rst_mem_addr", bus.mem_addr_o, 0);
      check("rst_d_ready", {31'b0, bus.d_ready_o}, 0);
      check("rst_i_ready", {31'b0, bus.i_ready_o}, 0);
      check("rst_d_rdata", bus.d_rdata_o, 0);
      check("rst_i_rdata", bus.i_rdata_o, 0);
      rst_n = 1'b1;
      tick();

      // data read of 0x10
      bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h10;
      tick();
      check("rd_issue_req", {31'b0, bus.mem_req_o}, 1);
      check("rd_issue_addr", bus.mem_addr_o, 32'h10);
      check("rd_issue_busy", {31'b0, bus.busy_o}, 1);
      check("rd_issue_we", {31'b0, bus.mem_we_o}, 0);
      tick();
      check("rd_d_ready", {31'b0, bus.d_ready_o}, 1);
      check("rd_d_rdata", bus.d_rdata_o, 32'hDEADBEEF);
      check("rd_i_ready", {31'b0, bus.i_ready_o}, 0);
      check("rd_i_rdata", bus.i_rdata_o, 0);
      bus.d_req_i = 0;
      tick();
      check("idle_busy", {31'b0, bus.busy_o}, 0);
      check("idle_mem_req", {31'b0, bus.mem_req_o}, 0);
      check("idle_mem_addr", bus.mem_addr_o, 0);
      check("idle_d_ready", {31'b0, bus.d_ready_o}, 0);

      // instruction-port byte write then readback
      bus.i_req_i = 1; bus.i_we_i = 1; bus.i_be_i = 4'b0010; bus.i_addr_i = 32'h4; bus.i_wdata_i = 32'h0000AB00;
      tick();
      check("wr_mem_we", {31'b0, bus.mem_we_o}, 1);
      check("wr_mem_be", {28'b0, bus.mem_be_o}, 32'h2);
      check("wr_mem_wdata", bus.mem_wdata_o, 32'h0000AB00);
      check("wr_mem_addr", bus.mem_addr_o, 32'h4);
      tick();
      check("wr_i_ready", {31'b0, bus.i_ready_o}, 1);
      check("wr_i_rdata", bus.i_rdata_o, 0);
      check("wr_d_ready", {31'b0, bus.d_ready_o}, 0);
      bus.i_req_i = 0; bus.i_we_i = 0; bus.i_be_i = 4'hF;
      tick();
      bus.i_req_i = 1;
      tick();
      tick();
      check("rb_i_ready", {31'b0, bus.i_ready_o}, 1);
      check("rb_i_rdata", bus.i_rdata_o, 32'h0000AB00);
      rbyte = bus.i_rdata_o[15:8];
      check("rb_byte1", {24'b0, rbyte}, 32'hAB);
      bus.i_req_i = 0;
      tick();

      // memory stalls four cycles in ISSUE
      bus.mem_ready_i = 0; bus.d_req_i = 1; bus.d_addr_i = 32'h10;
      tick();
      for (int k = 0; k < 4; k++) begin
         check("stall_addr", bus.mem_addr_o, 32'h10);
         check("stall_req", {31'b0, bus.mem_req_o}, 1);
         check("stall_d_ready", {31'b0, bus.d_ready_o}, 0);
         tick();
      end
      bus.mem_ready_i = 1;
      check("stall_still_issue", {31'b0, bus.mem_req_o}, 1);
      tick();
      check("stall_d_ready_7", {31'b0, bus.d_ready_o}, 1);
      check("stall_d_rdata", bus.d_rdata_o, 32'hDEADBEEF);
      bus.d_req_i = 0;
      tick();

      // address change after grant is ignored
      bus.i_req_i = 1; bus.i_we_i = 0; bus.i_addr_i = 32'h8; bus.mem_ready_i = 0;
      tick();
      check("latch_addr_a", bus.mem_addr_o, 32'h8);
      bus.i_addr_i = 32'hC;
      tick();
      check("latch_addr_b", bus.mem_addr_o, 32'h8);
      bus.mem_ready_i = 1;
      tick();
      check("latch_addr_resp", bus.mem_addr_o, 32'h8);
      check("latch_i_ready", {31'b0, bus.i_ready_o}, 1);
      check("latch_i_rdata", bus.i_rdata_o, 32'h12345678);
      bus.i_req_i = 0;
      tick();

      // reset during ISSUE aborts the transfer
      bus.d_req_i = 1; bus.d_addr_i = 32'h10;
      tick();
      check("abort_issue", {31'b0, bus.mem_req_o}, 1);
      rst_n = 0; bus.d_req_i = 0;
      tick();
      check("abort_busy", {31'b0, bus.busy_o}, 0);
      check("abort_mem_req", {31'b0, bus.mem_req_o}, 0);
      check("abort_d_ready", {31'b0, bus.d_ready_o}, 0);
      rst_n = 1;
      tick();
      check("abort_no_pulse", {31'b0, bus.d_ready_o}, 0);
      bus.i_req_i = 1; bus.i_addr_i = 32'h8; bus.i_we_i = 0;
      tick();
      tick();
      check("post_rst_i_ready", {31'b0, bus.i_ready_o}, 1);
      check("post_rst_i_rdata", bus.i_rdata_o, 32'h12345678);
      bus.i_req_i = 0;
      tick();

      // both ports requesting continuously
      bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h10;
      bus.i_req_i = 1; bus.i_we_i = 0; bus.i_addr_i = 32'h8;
      for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_d = (t % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         tick();
         check("tie_addr", bus.mem_addr_o, exp_d ? 32'h10 : 32'h8);
         tick();
         check("tie_d_ready", {31'b0, bus.d_ready_o}, {31'b0, exp_d});
         check("tie_i_ready", {31'b0, bus.i_ready_o}, {31'b0, ~exp_d});
         tick();
      end
      bus.d_req_i = 0; bus.i_req_i = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock, all logic on rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have instruction-port inputs i_req_i (1), i_we_i (1), i_be_i (4), i_addr_i (32), i_wdata_i (32): fetch requester.
REQ-004 SHALL have instruction-port outputs i_rdata_o (32) and i_ready_o (1): read data and one-cycle completion pulse.
REQ-005 SHALL have data-port inputs d_req_i (1), d_we_i (1), d_be_i (4), d_addr_i (32), d_wdata_i (32): load/store requester.
REQ-006 SHALL have data-port outputs d_rdata_o (32) and d_ready_o (1), with the same meaning as the instruction port.
REQ-007 SHALL have memory-side outputs mem_req_o (1), mem_we_o (1), mem_be_o (4), mem_addr_o (32), mem_wdata_o (32).
REQ-008 SHALL have memory-side inputs mem_rdata_i (32), valid one cycle after an accepted read, and mem_ready_i (1).
REQ-009 SHALL have output busy_o (1), high in every state except IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-011 IDLE: if any req is high, SHALL choose a winner, latch its we/be/addr/wdata and the grant, and enter ISSUE; otherwise SHALL stay in IDLE.
REQ-012 ISSUE: SHALL drive mem_req_o=1 with the latched fields; on mem_ready_i=1 SHALL enter RESP, else SHALL stay in ISSUE with the fields held.
REQ-013 RESP: SHALL pulse the winner's ready_o for exactly one cycle and SHALL enter IDLE.
REQ-014 RESP: for a read, the winner's rdata_o SHALL equal mem_rdata_i; for a write, it SHALL be 0.
REQ-015 The loser's ready_o SHALL stay 0, and its rdata_o SHALL be 0 in every state.
REQ-016 Latency SHALL be exactly 3 cycles from a req sampled in IDLE to ready_o, given mem_ready_i=1; the next grant SHALL be possible on the cycle after RESP.
REQ-017 mem_req_o SHALL be 0 outside ISSUE; mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o SHALL be 0 in IDLE.
REQ-018 Requesters SHALL hold req and fields until ready_o; changes after the grant SHALL be ignored because the fields are latched.
REQ-019 be SHALL pass through unmodified; the arbiter SHALL NOT perform alignment or masking.
REQ-020 A request deasserted before it is granted SHALL be dropped silently.

Reset
REQ-021 rst_ni=0 at a clock edge SHALL force IDLE, clear the latched fields, and set the priority pointer to the data port.
REQ-022 During and after reset, all outputs SHALL be 0.
REQ-023 Reset asserted in ISSUE or RESP SHALL abort the transfer: no ready_o pulse, and mem_req_o=0 from the next cycle.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, the port not granted last SHALL win; the pointer SHALL update on entry to RESP.
REQ-025 Macro ARB_ROUND_ROBIN_EN undefined: the data port SHALL always win ties (fixed priority), and no pointer state SHALL exist.

Verification
REQ-026 Reset then d_req_i=1 read at addr 0x10 with the memory word 0xDEADBEEF -> mem_req_o high in cycle 2, d_ready_o pulse in cycle 3, d_rdata_o=0xDEADBEEF.
REQ-027 i_req_i=1 write, be=4'b0010, wdata=0x0000AB00, addr 0x4 -> mem_we_o=1, mem_be_o=4'b0010 during ISSUE; then a read of 0x4 returns byte 1 = 0xAB.
REQ-028 Both req held high continuously with the macro defined -> grants alternate D, I, D, I, one ready_o every 3 cycles; undefined -> D only, i_ready_o never pulses.
REQ-029 mem_ready_i held 0 for 4 cycles in ISSUE -> mem_addr_o and the other fields stable, ready_o at cycle 3+4 relative to the grant.
REQ-030 rst_ni=0 during ISSUE -> no ready_o pulse, busy_o=0 and mem_req_o=0 the following cycle, a new request served normally afterwards.
REQ-031 i_addr_i changed from 0x8 to 0xC during ISSUE -> mem_addr_o stays 0x8 until RESP.
